wave_table_writer: RTL and testbench
====================================

# wave_table_writer

Loads a quarter-wave sine table into the sample memory read by the sine playback FSM. Accepts a stream of 10-bit samples over a valid/ready handshake and issues one registered memory write per accepted sample, at sequential addresses 0..MEM_SIZE-1. Signals completion so playback can be enabled. This is the writer for the quarter-wave table that the playback FSM only reads.

## Interface
- MEM_SIZE, 128, number of table entries (quarter period)
- ADDR_W, 7, write address width; MEM_SIZE ≤ 2^ADDR_W
- DATA_W, 10, sample width

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load
- abort  in  1  one-cycle request to cancel a load
- in_valid  in  1  sample present on in_data
- in_data  in  DATA_W  unsigned sample
- in_ready  out  1  writer accepts a sample this cycle
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  memory write address
- wr_data  out  DATA_W  memory write data
- busy  out  1  load in progress
- done  out  1  full table written
- error  out  1  sticky monotonicity violation (see Configuration)
- count  out  ADDR_W+1  samples accepted in current/last load

## Operation
- States: IDLE, LOAD, DONE; reset to IDLE.
- IDLE: in_ready=0. start → LOAD, count←0, error←0.
- LOAD: in_ready=1, busy=1. Transfer when in_valid&in_ready. Each transfer: wr_addr←count[ADDR_W-1:0], wr_data←in_data, wr_en←1 next cycle; count←count+1.
- Transfer that brings count to MEM_SIZE → DONE on the same edge; in_ready drops the next cycle. No sample beyond MEM_SIZE is ever accepted.
- DONE: done=1, in_ready=0, count holds MEM_SIZE. start → LOAD (restart, count←0, error←0, done←0).
- abort in LOAD or DONE → IDLE; done←0, count holds. Memory contents already written are not undone.
- start in LOAD: ignored. start and abort in the same cycle: abort wins.
- in_data is unsigned; no arithmetic on it except the comparison below. count never wraps: it saturates by construction at MEM_SIZE.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE; in_ready, wr_en, busy, done, error = 0; wr_addr, wr_data, count = 0.
- start→in_ready: 1 cycle (start sampled at edge N, in_ready=1 in cycle N+1).
- Accept→write: wr_en high exactly one cycle after the accepting edge; wr_addr/wr_data valid in that cycle and held until the next write.
- Full-rate: back-to-back transfers every cycle; MEM_SIZE samples load in MEM_SIZE cycles with in_valid held high.
- in_valid may drop at any time in LOAD; no write occurs for idle cycles.
- done rises one cycle after the final accepting edge, coincident with the final wr_en.
- abort on the same edge as a transfer: transfer is discarded (no wr_en, count unchanged).
- Reset mid-load: writes stop immediately; wr_en deasserts asynchronously.

## Configuration
- WAVE_MONOTONIC_CHECK_EN defined: writer keeps the previously accepted sample; any accepted sample strictly less than the previous one in the same load sets error (sticky until start or reset). First sample of a load is never flagged. The sample is still written. error rises with the wr_en of the offending sample.
- Undefined: no comparison logic or previous-sample register; error tied to 0.

## Test plan
- Reset then start, in_valid held, in_data = 0,8,16,…,1016 (MEM_SIZE=128) -> 128 wr_en pulses, wr_addr 0..127, wr_data matches, done=1 after 129 cycles from start, count=128, in_ready=0.
- Throttled source: in_valid toggling 1,0,1,0 -> writes only on valid cycles, addresses contiguous, no duplicates, done after 128 accepts.
- abort after 40 accepts -> IDLE, count=40, done=0, no further wr_en; subsequent start reloads from addr 0.
- start and abort same cycle in IDLE -> remains IDLE; start while in LOAD at count=10 -> ignored, count continues 11.
- With WAVE_MONOTONIC_CHECK_EN: samples 0,5,3,6 -> error rises with write of 3 and stays 1 through DONE; without macro error stays 0.
- rst_n asserted mid-load at count=64 -> wr_en, busy, in_ready drop immediately; all outputs at reset values.

Source files
------------

// File: rtl/wave_table_writer.sv
// -----------------------------------------------------------------------------
// wave_table_writer
//   Loads the quarter-wave sine table that the playback FSM reads. Samples
//   arrive over a valid/ready handshake. Each accepted sample becomes one
//   registered memory write, at sequential addresses 0..MEM_SIZE-1. done is
//   raised once the whole table has been written.
//
//   Optional feature (compile-time macro WAVE_MONOTONIC_CHECK_EN):
//     Flags any accepted sample that is strictly smaller than the previous
//     sample of the same load. The flag is sticky on error.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         one-cycle load request / cancel (abort wins)
//   in_valid, in_data    sample stream
//   in_ready             handshake ready (LOAD only)
//   wr_en/addr/data      memory write port, one cycle after acceptance
//   busy, done           load in progress / full table written
//   error                sticky monotonicity violation (0 when feature off)
//   count                samples accepted in current/last load
// -----------------------------------------------------------------------------
module wave_table_writer #(
   parameter int unsigned MEM_SIZE = 128,
   parameter int unsigned ADDR_W   = 7,
   parameter int unsigned DATA_W   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

   state_e              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic                accept_c;
   logic                restart_c;
   logic [CNT_W-1:0]    cnt_inc_c;
   logic                last_c;

   // A handshake that coincides with abort is discarded.
   assign accept_c  = in_ready_q & in_valid & ~abort;
   assign cnt_inc_c = count_q + CNT_W'(1);
   assign last_c    = (cnt_inc_c == CNT_W'(MEM_SIZE));
   assign restart_c = (state_q != ST_LOAD) && (state_d == ST_LOAD);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start && !abort) state_d = ST_LOAD;
         ST_LOAD: begin
            if (abort)                  state_d = ST_IDLE;
            else if (accept_c && last_c) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (abort)      state_d = ST_IDLE;
            else if (start) state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values; status flags follow the next state.
   always_comb begin
      in_ready_d = (state_d == ST_LOAD);
      busy_d     = (state_d == ST_LOAD);
      done_d     = (state_d == ST_DONE);
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      count_d    = count_q;
      if (restart_c) begin
         count_d = '0;
      end else if (accept_c) begin
         wr_en_d   = 1'b1;
         wr_addr_d = count_q[ADDR_W-1:0];
         wr_data_d = in_data;
         count_d   = cnt_inc_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         count_q    <= '0;
      end else begin
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         count_q    <= count_d;
      end
   end

`ifdef WAVE_MONOTONIC_CHECK_EN
   logic              error_q, error_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic              have_prev_q, have_prev_d;

   // Compare against the previous sample of this load; the first is exempt.
   always_comb begin
      error_d     = error_q;
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      if (restart_c) begin
         error_d     = 1'b0;
         have_prev_d = 1'b0;
      end else if (accept_c) begin
         prev_d      = in_data;
         have_prev_d = 1'b1;
         if (have_prev_q && (in_data < prev_q)) error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_q     <= 1'b0;
         prev_q      <= '0;
         have_prev_q <= 1'b0;
      end else begin
         error_q     <= error_d;
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign count    = count_q;

endmodule

// File: tb/tb_wave_table_writer.sv
// -----------------------------------------------------------------------------
// tb_wave_table_writer
//   Directed testbench for wave_table_writer. It checks full-rate loading,
//   throttled loading, abort, start/abort priority, the monotonic flag, and
//   asynchronous reset in the middle of a load. A negedge monitor logs every
//   memory write so that each load can be compared with its expected table.
// -----------------------------------------------------------------------------
module tb_wave_table_writer;

   localparam int unsigned MEM_SIZE = 128;
   localparam int unsigned ADDR_W   = 7;
   localparam int unsigned DATA_W   = 10;
`ifdef WAVE_MONOTONIC_CHECK_EN
   localparam logic MONO = 1'b1;
`else
   localparam logic MONO = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, abort, in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, wr_en, busy, done, error;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W:0]   count;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;
   int base;
   logic [ADDR_W-1:0] log_addr [1024];
   logic [DATA_W-1:0] log_data [1024];

   always #5 clk = ~clk;

   wave_table_writer #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .count    (count)
   );

   // Write monitor: log every memory write in order.
   always @(negedge clk) begin
      if (wr_en) begin
         if (wr_cnt < 1024) begin
            log_addr[wr_cnt] = wr_addr;
            log_data[wr_cnt] = wr_data;
         end
         wr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Logged writes from index b must be addr k, data k*mul+off, n entries total.
   task automatic check_log(input string tag, input int b, input int n, input int mul, input int off);
      int bad;
      bad = 0;
      for (int k = 0; k < n; k++) begin
         if (log_addr[b+k] !== ADDR_W'(k))         bad++;
         if (log_data[b+k] !== DATA_W'(k*mul+off)) bad++;
      end
      check({tag, "_entries"}, 32'(bad), 0);
      check({tag, "_nwrites"}, 32'(wr_cnt - b), 32'(n));
   endtask

   task automatic do_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DATA_W-1:0] seq [4];
      logic              seq_err [4];
      int k;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      #12;
      // ---- reset values
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_wr_en",    32'(wr_en), 0);
      check("rst_busy",     32'(busy), 0);
      check("rst_done",     32'(done), 0);
      check("rst_error",    32'(error), 0);
      check("rst_count",    32'(count), 0);
      check("rst_wr_addr",  32'(wr_addr), 0);
      check("rst_wr_data",  32'(wr_data), 0);
      @(negedge clk) rst_n = 1'b1;
      step(1);
      check("idle_in_ready", 32'(in_ready), 0);

      // ---- full-rate load: 0,8,...,1016
      base = wr_cnt;
      do_start();
      check("t1_ready_after_start", 32'(in_ready), 1);
      check("t1_busy", 32'(busy), 1);
      check("t1_count0", 32'(count), 0);
      in_valid = 1'b1;
      for (int i = 0; i < 128; i++) begin
         in_data = DATA_W'(8*i);
         step(1);
         if (i == 126) check("t1_done_early", 32'(done), 0);
      end
      check("t1_done", 32'(done), 1);
      check("t1_final_wr_en", 32'(wr_en), 1);
      check("t1_final_addr", 32'(wr_addr), 127);
      check("t1_count", 32'(count), 128);
      check("t1_in_ready", 32'(in_ready), 0);
      check("t1_busy_off", 32'(busy), 0);
      step(3);
      in_valid = 1'b0;
      check("t1_done_hold", 32'(done), 1);
      check("t1_count_hold", 32'(count), 128);
      check_log("t1", base, 128, 8, 0);
      check("t1_error", 32'(error), 0);

      // ---- throttled load from DONE
      base = wr_cnt;
      do_start();
      check("t2_done_cleared", 32'(done), 0);
      check("t2_count0", 32'(count), 0);
      k = 0;
      for (int c = 0; c < 256; c++) begin
         in_valid = (c % 2 == 0);
         if (in_valid) begin
            in_data = DATA_W'(8*k + 1);
            k++;
         end
         step(1);
      end
      in_valid = 1'b0;
      check("t2_done", 32'(done), 1);
      check("t2_count", 32'(count), 128);
      step(1);
      check_log("t2", base, 128, 8, 1);

      // ---- abort after 40 accepts, abort coincident with a handshake
      base = wr_cnt;
      do_start();
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_data = DATA_W'(i);
         step(1);
      end
      abort = 1'b1; in_data = DATA_W'(999);
      step(1);
      abort = 1'b0;
      check("t3_busy", 32'(busy), 0);
      check("t3_in_ready", 32'(in_ready), 0);
      check("t3_done", 32'(done), 0);
      check("t3_count", 32'(count), 40);
      check("t3_wr_en", 32'(wr_en), 0);
      step(3);
      in_valid = 1'b0;
      check("t3_count_hold", 32'(count), 40);
      check_log("t3", base, 40, 1, 0);
      base = wr_cnt;
      do_start();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = DATA_W'(100 + i);
         step(1);
      end
      in_valid = 1'b0;
      step(1);
      check_log("t3_reload", base, 3, 1, 100);
      abort = 1'b1;
      step(1);
      abort = 1'b0;

      // ---- start+abort in IDLE; start ignored in LOAD
      start = 1'b1; abort = 1'b1;
      step(1);
      start = 1'b0; abort = 1'b0;
      check("t4_idle_busy", 32'(busy), 0);
      check("t4_idle_ready", 32'(in_ready), 0);
      step(2);
      check("t4_idle_stay", 32'(busy), 0);
      do_start();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = DATA_W'(2*i);
         step(1);
      end
      check("t4_count10", 32'(count), 10);
      start = 1'b1; in_data = DATA_W'(20);
      step(1);
      start = 1'b0; in_valid = 1'b0;
      check("t4_count11", 32'(count), 11);
      check("t4_still_busy", 32'(busy), 1);
      check("t4_addr10", 32'(wr_addr), 10);
      abort = 1'b1;
      step(1);
      abort = 1'b0;

      // ---- monotonic check: 0,5,3,6
      seq[0] = DATA_W'(0); seq[1] = DATA_W'(5); seq[2] = DATA_W'(3); seq[3] = DATA_W'(6);
      seq_err[0] = 1'b0; seq_err[1] = 1'b0; seq_err[2] = MONO; seq_err[3] = MONO;
      do_start();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = seq[i];
         step(1);
         check($sformatf("t5_error_%0d", i), 32'(error), 32'(seq_err[i]));
         check($sformatf("t5_data_%0d", i), 32'(wr_data), 32'(seq[i]));
      end
      in_data = DATA_W'(1023);
      step(124);
      in_valid = 1'b0;
      check("t5_done", 32'(done), 1);
      check("t5_error_sticky", 32'(error), 32'(MONO));
      do_start();
      check("t5_error_cleared", 32'(error), 0);
      in_valid = 1'b1;
      in_data = DATA_W'(0);
      step(1);
      check("t5_first_not_flagged", 32'(error), 0);
      in_data = DATA_W'(1);
      step(1);
      in_valid = 1'b0;
      check("t5_second_ok", 32'(error), 0);
      abort = 1'b1;
      step(1);
      abort = 1'b0;

      // ---- reset mid-load at count 64
      do_start();
      in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         in_data = DATA_W'(i);
         step(1);
      end
      check("t6_count64", 32'(count), 64);
      check("t6_wr_en_pre", 32'(wr_en), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_wr_en", 32'(wr_en), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_in_ready", 32'(in_ready), 0);
      check("t6_count", 32'(count), 0);
      check("t6_wr_addr", 32'(wr_addr), 0);
      check("t6_wr_data", 32'(wr_data), 0);
      check("t6_done", 32'(done), 0);
      check("t6_error", 32'(error), 0);
      in_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      step(2);
      check("t6_idle_after", 32'(busy), 0);
      check("t6_no_write", 32'(wr_en), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
